des_stream_ctrl: RTL and testbench
==================================

Name: des_stream_ctrl

Overview:
- Streaming front/back-end controller for the 16-round pipelined DES core. It drives the core's key-change, enable and data inputs, and collects the core's un-flagged output.
- It adds valid/ready handshakes on the plaintext/ciphertext streams and a key-load handshake.
- It tracks in-flight blocks with a tag shift register, because the core pipeline only advances on its enable.
- It sits between the system stream fabric and the DES core, on the core's driving side.

Parameters:
PIPE_DEPTH, 16, number of enable-advanced register stages in the core from data input to the valid combinational output.
OCC_W, 5, width of the occupancy counter; must hold PIPE_DEPTH.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  new key/mode offered
key_ready  out  1  key accepted when key_valid&&key_ready
key_in  in  [1:64]  64-bit DES key including parity bits
key_encrypt  in  1  mode for this key: 1 = encrypt, 0 = decrypt
s_valid  in  1  input block valid
s_ready  out  1  input block accepted when s_valid&&s_ready (s_fire)
s_data  in  [1:64]  input block
m_valid  out  1  output block valid
m_ready  in  1  downstream accepts
m_data  out  [1:64]  output block
core_encrypt  out  1  to core encrypt
core_keys_64  out  [1:64]  to core keys_64_in
core_change_keys_en  out  1  to core change_keys_en
core_subkeys_valid  in  1  from core subkeys_16_valid
core_data_input_en  out  1  to core data_input_en (pipeline advance, adv)
core_data_64_in  out  [1:64]  to core data_64_in
core_data_64_out  in  [1:64]  from core data_64_out
occupancy  out  OCC_W  blocks in flight inside the core
busy  out  1  state != RUN, or occupancy != 0

Behaviour:
- Reset values: state = IDLE; key/mode registers = 0; tag = 0; occupancy = 0; m_valid = 0; m_data = 0. All outputs follow from these registers.
- States: IDLE, KEYRST, KEYGEN, RUN, DRAIN.
- IDLE: key_ready = 1, core_change_keys_en = 0. On key fire, latch key_in and key_encrypt, go to KEYGEN.
- KEYGEN: core_change_keys_en = 1, key_ready = 0. Go to RUN when core_subkeys_valid = 1.
- RUN: key_ready = 1, core_change_keys_en = 1. On key fire, latch the new key/mode into pending registers and go to DRAIN. A simultaneous s_fire in the same cycle is still accepted.
- DRAIN: key_ready = 0, s_ready = 0, core_change_keys_en = 1, core_keys_64 and core_encrypt still carry the old key. When occupancy = 0, copy pending to active and go to KEYRST.
- KEYRST: core_change_keys_en = 0. Stay until core_subkeys_valid = 0 (minimum 1 cycle), then go to KEYGEN.
- Output-free condition: ofree = !tag[PIPE_DEPTH] || !m_valid || m_ready.
- s_ready = (state == RUN) && core_subkeys_valid && ofree. This is a combinational path from m_ready to s_ready.
- adv = core_subkeys_valid && ofree && (s_fire || occupancy != 0), gated to states RUN or DRAIN. core_data_input_en = adv.
- core_data_64_in = s_data when s_fire, else 64'h0. Bubbles are pushed only to drain the pipeline.
- Tag shift on adv: tag[1] <= s_fire; tag[i] <= tag[i-1]. No shift without adv.
- Output capture: on adv && tag[PIPE_DEPTH], m_data <= core_data_64_out and m_valid <= 1. Otherwise, m_valid clears on m_ready.
- occupancy: +1 on s_fire; -1 on adv && tag[PIPE_DEPTH]; unchanged when both happen in the same cycle. Never exceeds PIPE_DEPTH.
- Latency with no backpressure: a block accepted in cycle 0 shows m_valid = 1 in cycle 17. Throughput is 1 block/cycle.
- m_valid held with m_ready = 0 while tag[PIPE_DEPTH] = 1: the pipeline stalls with no loss and no duplication. m_data stays stable while m_valid && !m_ready.
- core_subkeys_valid dropping in RUN: the pipeline freezes (adv = 0), state is held.
- A pending m_valid block survives a key change and is unaffected by it.
- Asynchronous reset mid-operation discards all in-flight blocks and the output register.

Test Plan:
- Encrypt vector: key 133457799BBCDFF1, encrypt = 1, one block 0123456789ABCDEF in cycle 0 -> m_data = 85E813540F0AB405 with m_valid in cycle 17; occupancy returns to 0.
- Stream 20 back-to-back blocks with m_ready = 1 -> 20 outputs in order on consecutive cycles, first one in cycle 17; s_ready stays 1 throughout.
- Backpressure: m_ready = 0 for cycles 18-30 during a 20-block stream -> m_data stable while stalled, no loss or duplicate, s_ready = 0 while the stall blocks ofree, all 20 outputs correct.
- Key change mid-stream: 5 blocks in flight, then new key offered with encrypt = 0 -> state DRAIN, all 5 outputs use the old key, KEYRST→KEYGEN→RUN. Decrypting 85E813540F0AB405 with key 133457799BBCDFF1 then yields 0123456789ABCDEF.
- Simultaneous key fire and s_fire in RUN -> that block is processed with the old key and occupancy counts it before the drain completes.
- Assert rst_n = 0 with 8 blocks in flight and m_valid = 1 -> m_valid = 0, occupancy = 0, state IDLE, s_ready = 0 immediately.

Source files
------------

// File: rtl/des_stream_ctrl.sv
// Streaming valid/ready front/back-end for a 16-round enable-advanced DES pipeline.
// Tracks in-flight blocks with a tag shift register and sequences key reloads around them.
module des_stream_ctrl #(
    parameter int PIPE_DEPTH = 16,
    parameter int OCC_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [1:64]      key_in,
    input  logic             key_encrypt,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [1:64]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:64]      m_data,
    output logic             core_encrypt,
    output logic [1:64]      core_keys_64,
    output logic             core_change_keys_en,
    input  logic             core_subkeys_valid,
    output logic             core_data_input_en,
    output logic [1:64]      core_data_64_in,
    input  logic [1:64]      core_data_64_out,
    output logic [OCC_W-1:0] occupancy,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYRST = 3'd1,
        KEYGEN = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [1:64]            key_q, key_d;
    logic                   enc_q, enc_d;
    logic [1:64]            pend_key_q, pend_key_d;
    logic                   pend_enc_q, pend_enc_d;
    logic [1:PIPE_DEPTH]    tag_q, tag_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic                   m_valid_q, m_valid_d;
    logic [1:64]            m_data_q, m_data_d;

    logic                   key_ready_s;
    logic                   s_ready_s;
    logic                   s_fire_s;
    logic                   key_fire_s;
    logic                   ofree_s;
    logic                   adv_s;
    logic                   out_cap_s;

    // Handshake and pipeline-advance decode
    always_comb begin
        key_ready_s = (state_q == IDLE) || (state_q == RUN);
        ofree_s     = !tag_q[PIPE_DEPTH] || !m_valid_q || m_ready;
        s_ready_s   = (state_q == RUN) && core_subkeys_valid && ofree_s;
        s_fire_s    = s_valid && s_ready_s;
        key_fire_s  = key_valid && key_ready_s;
        // Bubbles are only pushed while something is still inside the core
        adv_s       = ((state_q == RUN) || (state_q == DRAIN)) && core_subkeys_valid && ofree_s
                      && (s_fire_s || (occ_q != '0));
        out_cap_s   = adv_s && tag_q[PIPE_DEPTH];
    end

    // Key sequencing state machine next-state logic
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        enc_d      = enc_q;
        pend_key_d = pend_key_q;
        pend_enc_d = pend_enc_q;
        case (state_q)
            IDLE: begin
                if (key_fire_s) begin
                    key_d   = key_in;
                    enc_d   = key_encrypt;
                    state_d = KEYGEN;
                end else begin
                    state_d = IDLE;
                end
            end
            KEYGEN: begin
                if (core_subkeys_valid) begin
                    state_d = RUN;
                end else begin
                    state_d = KEYGEN;
                end
            end
            RUN: begin
                if (key_fire_s) begin
                    pend_key_d = key_in;
                    pend_enc_d = key_encrypt;
                    state_d    = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // The old key stays on the core until every tagged block has left it
                if (occ_q == '0) begin
                    key_d   = pend_key_q;
                    enc_d   = pend_enc_q;
                    state_d = KEYRST;
                end else begin
                    state_d = DRAIN;
                end
            end
            KEYRST: begin
                if (!core_subkeys_valid) begin
                    state_d = KEYGEN;
                end else begin
                    state_d = KEYRST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tag shift, occupancy and output register next-state logic
    always_comb begin
        if (adv_s) begin
            tag_d = {s_fire_s, tag_q[1:PIPE_DEPTH-1]};
        end else begin
            tag_d = tag_q;
        end

        case ({s_fire_s, out_cap_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        m_data_d = m_data_q;
        if (out_cap_s) begin
            m_valid_d = 1'b1;
            m_data_d  = core_data_64_out;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_q      <= 64'h0;
            enc_q      <= 1'b0;
            pend_key_q <= 64'h0;
            pend_enc_q <= 1'b0;
            tag_q      <= '0;
            occ_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= 64'h0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            enc_q      <= enc_d;
            pend_key_q <= pend_key_d;
            pend_enc_q <= pend_enc_d;
            tag_q      <= tag_d;
            occ_q      <= occ_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
        end
    end

    assign key_ready           = key_ready_s;
    assign s_ready             = s_ready_s;
    assign m_valid             = m_valid_q;
    assign m_data              = m_data_q;
    assign core_encrypt        = enc_q;
    assign core_keys_64        = key_q;
    assign core_change_keys_en = (state_q == KEYGEN) || (state_q == RUN) || (state_q == DRAIN);
    assign core_data_input_en  = adv_s;
    assign core_data_64_in     = s_fire_s ? s_data : 64'h0;
    assign occupancy           = occ_q;
    assign busy                = (state_q != RUN) || (occ_q != '0);

endmodule

// File: tb/tb_des_stream_ctrl.sv
// Bench for des_stream_ctrl: behavioural core stand-in, scoreboard monitor, vector table
// and directed sequences for key change, backpressure and reset.
module tb_des_stream_ctrl;
    localparam int PD = 16;
    localparam int OW = 5;
    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_valid = 1'b0;
    logic          key_ready;
    logic [1:64]   key_in = 64'h0;
    logic          key_encrypt = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [1:64]   s_data = 64'h0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [1:64]   m_data;
    logic          core_encrypt;
    logic [1:64]   core_keys_64;
    logic          core_change_keys_en;
    logic          core_subkeys_valid;
    logic          core_data_input_en;
    logic [1:64]   core_data_64_in;
    logic [1:64]   core_data_64_out;
    logic [OW-1:0] occupancy;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    des_stream_ctrl #(.PIPE_DEPTH(PD), .OCC_W(OW)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in), .key_encrypt(key_encrypt),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .core_encrypt(core_encrypt), .core_keys_64(core_keys_64),
        .core_change_keys_en(core_change_keys_en), .core_subkeys_valid(core_subkeys_valid),
        .core_data_input_en(core_data_input_en), .core_data_64_in(core_data_64_in),
        .core_data_64_out(core_data_64_out), .occupancy(occupancy), .busy(busy)
    );

    // Core stand-in: known-answer DES pairs, otherwise a cheap key/mode-dependent mix
    function automatic logic [63:0] cfun(input logic [63:0] k, input logic e, input logic [63:0] d);
        if (k == KAT_KEY && e && d == KAT_PT) return KAT_CT;
        if (k == KAT_KEY && !e && d == KAT_CT) return KAT_PT;
        if (e) return d ^ k ^ 64'hA5A50F0F3C3C9696;
        return {d[31:0], d[63:32]} ^ k;
    endfunction

    logic [63:0] pipe [1:PD];
    logic        sv_r;
    logic [1:0]  kcnt;

    always @(posedge clk) begin
        if (core_data_input_en) begin
            pipe[1] <= core_data_64_in;
            for (int i = 2; i <= PD; i++) pipe[i] <= pipe[i-1];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv_r <= 1'b0;
            kcnt <= 2'd0;
        end else if (!core_change_keys_en) begin
            sv_r <= 1'b0;
            kcnt <= 2'd0;
        end else if (kcnt == 2'd3) begin
            sv_r <= 1'b1;
        end else begin
            kcnt <= kcnt + 2'd1;
        end
    end

    assign core_subkeys_valid = sv_r;
    assign core_data_64_out   = cfun(core_keys_64, core_encrypt, pipe[PD]);

    logic [63:0] exp_q [$];
    int          fire_q [$];
    logic [63:0] sb_key = 64'h0;
    logic        sb_enc = 1'b0;
    logic [63:0] last_out = 64'h0;
    int          last_lat = 0;
    int          out_cnt = 0;
    logic        lat_chk = 1'b0;

    typedef struct {
        logic [63:0] key;
        logic        enc;
        logic [63:0] din;
        logic [63:0] dout;
    } vec_t;
    vec_t vecs [0:4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    task automatic monitor();
        logic        stall_p = 1'b0;
        logic [63:0] stall_d = 64'h0;
        logic [63:0] e;
        int          fc;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_p = 1'b0;
                continue;
            end
            if (core_data_input_en && !(s_valid && s_ready))
                chk("bubble_zero", core_data_64_in, 64'h0);
            if (m_valid && !m_ready && occupancy == OW'(PD))
                chk("stall_s_ready", {63'd0, s_ready}, 64'd0);
            if (stall_p && m_valid)
                chk("m_data_stable", m_data, stall_d);
            stall_p = m_valid && !m_ready;
            stall_d = m_data;
            if (s_valid && s_ready) begin
                exp_q.push_back(cfun(sb_key, sb_enc, s_data));
                fire_q.push_back(cyc);
            end
            // Blocks accepted alongside a key fire still belong to the old key
            if (key_valid && key_ready) begin
                sb_key = key_in;
                sb_enc = key_encrypt;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got unexpected output %h", m_data);
                end else begin
                    e  = exp_q.pop_front();
                    fc = fire_q.pop_front();
                    chk("sb_data", m_data, e);
                    last_out = m_data;
                    last_lat = cyc - fc;
                    out_cnt++;
                    if (lat_chk) chk("sb_latency", 64'(last_lat), 64'd17);
                end
            end
        end
    endtask

    task automatic wait_run(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || !key_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout(name);
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [63:0] k, input logic e);
        int n = 0;
        key_in = k;
        key_encrypt = e;
        key_valid = 1'b1;
        @(negedge clk);
        while (!key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("key_fire");
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        wait_run("key_to_run");
    endtask

    task automatic send_stream(input int n, input logic [63:0] base, input logic strict);
        int i = 0;
        int g = 0;
        s_valid = 1'b1;
        while (i < n && g < 2000) begin
            s_data = base + 64'(i) * 64'h0101010101010101;
            @(negedge clk);
            if (strict) chk("s_ready_stream", {63'd0, s_ready}, 64'd1);
            if (s_ready) i++;
            @(posedge clk);
            #1;
            g++;
        end
        s_valid = 1'b0;
        if (i < n) timeout("send_stream");
    endtask

    task automatic expect_out(input string name, input logic [63:0] exp, input logic chk_lat);
        int n0 = out_cnt;
        int g = 0;
        while (out_cnt == n0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (out_cnt == n0) begin
            timeout(name);
        end else begin
            chk(name, last_out, exp);
            if (chk_lat) chk({name, "_lat"}, 64'(last_lat), 64'd17);
        end
    endtask

    task automatic wait_empty(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || m_valid) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) timeout(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_cnt;
        int g;
        vecs[0] = '{KAT_KEY, 1'b1, KAT_PT, KAT_CT};
        vecs[1] = '{KAT_KEY, 1'b0, KAT_CT, KAT_PT};
        vecs[2] = '{64'h0, 1'b1, 64'h0, 64'hA5A50F0F3C3C9696};
        vecs[3] = '{64'h0, 1'b0, 64'h0000000100000002, 64'h0000000200000001};
        vecs[4] = '{64'hFEDCBA9876543210, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hA4864A68B5975B79};

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_key_ready", {63'd0, key_ready}, 64'd1);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_m_data", m_data, 64'h0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd1);
        chk("rst_change_keys", {63'd0, core_change_keys_en}, 64'd0);
        chk("rst_keys", core_keys_64, 64'h0);
        @(posedge clk);
        #1;

        lat_chk = 1'b1;
        for (int v = 0; v < 5; v++) begin
            load_key(vecs[v].key, vecs[v].enc);
            send_stream(1, vecs[v].din, 1'b1);
            expect_out("vec_out", vecs[v].dout, 1'b1);
            wait_empty("vec_drain");
            chk("vec_occ_zero", 64'(occupancy), 64'd0);
        end

        load_key(KAT_KEY, 1'b1);
        base_cnt = out_cnt;
        send_stream(20, 64'h1000000000000000, 1'b1);
        wait_empty("stream_drain");
        chk("stream_count", 64'(out_cnt - base_cnt), 64'd20);

        lat_chk = 1'b0;
        base_cnt = out_cnt;
        fork
            send_stream(20, 64'h2000000000000000, 1'b0);
            begin
                repeat (18) @(posedge clk);
                #1 m_ready = 1'b0;
                @(negedge clk);
                chk("bp_s_ready", {63'd0, s_ready}, 64'd0);
                repeat (13) @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join
        wait_empty("bp_drain");
        chk("bp_count", 64'(out_cnt - base_cnt), 64'd20);

        lat_chk = 1'b1;
        base_cnt = out_cnt;
        send_stream(5, KAT_PT, 1'b1);
        key_in = KAT_KEY;
        key_encrypt = 1'b0;
        key_valid = 1'b1;
        @(negedge clk);
        chk("kc_key_ready_run", {63'd0, key_ready}, 64'd1);
        @(posedge clk);
        #1 key_valid = 1'b0;
        @(negedge clk);
        chk("kc_drain_key_ready", {63'd0, key_ready}, 64'd0);
        chk("kc_drain_s_ready", {63'd0, s_ready}, 64'd0);
        chk("kc_drain_change_en", {63'd0, core_change_keys_en}, 64'd1);
        chk("kc_drain_old_mode", {63'd0, core_encrypt}, 64'd1);
        chk("kc_drain_busy", {63'd0, busy}, 64'd1);
        g = 0;
        while (core_change_keys_en && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) timeout("kc_keyrst");
        chk("kc_keyrst_new_mode", {63'd0, core_encrypt}, 64'd0);
        chk("kc_keyrst_occ", 64'(occupancy), 64'd0);
        @(posedge clk);
        #1;
        wait_run("kc_to_run");
        chk("kc_old_key_outputs", 64'(out_cnt - base_cnt), 64'd5);
        send_stream(1, KAT_CT, 1'b1);
        expect_out("kc_decrypt", KAT_PT, 1'b1);
        wait_empty("kc_drain");

        s_data = KAT_CT;
        s_valid = 1'b1;
        key_in = 64'h0;
        key_encrypt = 1'b1;
        key_valid = 1'b1;
        @(negedge clk);
        chk("simul_s_ready", {63'd0, s_ready}, 64'd1);
        chk("simul_key_ready", {63'd0, key_ready}, 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        chk("simul_occ", 64'(occupancy), 64'd1);
        chk("simul_drain", {63'd0, key_ready}, 64'd0);
        expect_out("simul_old_key", KAT_PT, 1'b1);
        wait_run("simul_to_run");

        lat_chk = 1'b0;
        m_ready = 1'b0;
        send_stream(1, 64'hAAAAAAAAAAAAAAAA, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        send_stream(8, 64'h5555555555555555, 1'b1);
        @(negedge clk);
        chk("pre_rst_m_valid", {63'd0, m_valid}, 64'd1);
        chk("pre_rst_occ", 64'(occupancy), 64'd8);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("async_rst_occ", 64'(occupancy), 64'd0);
        chk("async_rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("async_rst_idle", {63'd0, key_ready}, 64'd1);
        chk("async_rst_m_data", m_data, 64'h0);
        exp_q.delete();
        fire_q.delete();
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("post_rst_change_en", {63'd0, core_change_keys_en}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
